// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the two-entry skid buffer
package pipe_pkg;

    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;

    localparam int SKID_DEPTH = 2;

    function automatic logic [1:0] occ_of(input skid_state_t s);
        case (s)
            SKID_ONE:  return 2'd1;
            SKID_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_ctrl.sv
// rtl/skid_ctrl.sv - skid buffer FSM: state, registered in_ready/occupancy, datapath load strobes
module skid_ctrl
    import pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    input  logic        out_ready_i,
    output skid_state_t state_o,
    output logic        in_ready_o,
    output logic [1:0]  occupancy_o,
    output logic        load_main_o,
    output logic        load_skid_o,
    output logic        sel_skid_o
);

    skid_state_t state_q, state_d;
    logic        in_ready_q;
    logic [1:0]  occ_q;
    logic        push, pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = (state_q != SKID_EMPTY) & out_ready_i;

    always_comb begin
        state_d     = state_q;
        load_main_o = 1'b0;
        load_skid_o = 1'b0;
        sel_skid_o  = 1'b0;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        load_main_o = 1'b1;
                        state_d     = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        load_main_o = 1'b1;
                    end else if (push) begin
                        load_skid_o = 1'b1;
                        state_d     = SKID_FULL;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        load_main_o = 1'b1;
                        sel_skid_o  = 1'b1;
                        state_d     = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // in_ready and occupancy are decoded from the next state so they leave the FSM as flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (occ_of(state_d) != 2'(SKID_DEPTH));
            occ_q      <= occ_of(state_d);
        end
    end

    assign state_o     = state_q;
    assign in_ready_o  = in_ready_q;
    assign occupancy_o = occ_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry elastic pipeline register with registered in_ready
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    skid_state_t  state;
    logic         load_main, load_skid, sel_skid;
    logic [N-1:0] main_q, main_d;
    logic [N-1:0] skid_q;

    skid_ctrl u_ctrl (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .state_o     (state),
        .in_ready_o  (in_ready),
        .occupancy_o (occupancy),
        .load_main_o (load_main),
        .load_skid_o (load_skid),
        .sel_skid_o  (sel_skid)
    );

    assign main_d = sel_skid ? skid_q : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_d;
            if (load_skid) skid_q <= in_data;
        end
    end

    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = main_q;

endmodule
